bfly22_sched: RTL and testbench

Frame-level scheduler for the 16-lane radix-2 butterfly stage of the FFT pipeline. It sequences one frame of BLK_PER_FRAME sample blocks from the upstream source into the butterfly datapath. Issue is gated by a credit count for the downstream buffer, because the butterfly has a fixed 2-cycle latency and cannot stall. It also tracks blocks in flight and tags the butterfly outputs with start-of-frame and end-of-frame markers.

---
 rtl/bfly22_sched.sv | 159 +++++++++++++++
 tb/tb_bfly22_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bfly22_sched.sv
// Frame scheduler for the 16-lane radix-2 butterfly stage: credit-gated block issue,
// in-flight tracking and start/end-of-frame tagging of the butterfly outputs.
module bfly22_sched #(
    parameter int NUM           = 16,
    parameter int BLK_PER_FRAME = 32,
    parameter int LAT           = 2,
    parameter int CREDITS       = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic                               bf_valid_in,
    input  logic                               bf_valid_out,
    input  logic                               credit_ret,
    output logic                               out_sof,
    output logic                               out_eof,
    output logic [$clog2(BLK_PER_FRAME+1)-1:0] blk_cnt,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int CW  = $clog2(BLK_PER_FRAME + 1);
    localparam int CRW = $clog2(CREDITS + 1);
    localparam int IW  = $clog2(LAT + 1);
    localparam logic [CW-1:0]  LAST_BLK   = CW'(BLK_PER_FRAME - 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(CREDITS);

    if (NUM < 1 || BLK_PER_FRAME < 2 || LAT < 1 || CREDITS < 1) begin : g_param_check
        $error("bfly22_sched: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   blk_cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;
    logic [CRW-1:0]  credit_reg;
    logic [CRW-1:0]  credit_next;
    logic [IW-1:0]   inflight_reg;
    logic [IW-1:0]   inflight_next;
    logic            err_next;
    logic            issue;
    logic            sof_in;
    logic            eof_in;
    logic [1:0]      tag_last;

    assign s_ready     = (state_reg == RUN) && (credit_reg != '0) && !abort;
    assign issue       = s_valid && s_ready;
    assign bf_valid_in = issue;
    assign sof_in      = issue && (blk_cnt_reg == '0);
    assign eof_in      = issue && (blk_cnt_reg == LAST_BLK);

    always_comb begin
        credit_next = credit_reg;
        if (issue && !credit_ret)
            credit_next = credit_reg - CRW'(1);
        else if (!issue && credit_ret && credit_reg != CREDIT_MAX)
            credit_next = credit_reg + CRW'(1);
    end

    // An output with nothing in flight is spurious; the counter saturates at zero.
    always_comb begin
        inflight_next = inflight_reg;
        if (issue && !bf_valid_out)
            inflight_next = inflight_reg + IW'(1);
        else if (!issue && bf_valid_out && inflight_reg != '0)
            inflight_next = inflight_reg - IW'(1);
    end

    assign err_next = err_reg
                    || (!issue && credit_ret && credit_reg == CREDIT_MAX)
                    || (bf_valid_out && inflight_reg == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_reg   <= CREDIT_MAX;
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            credit_reg   <= credit_next;
            inflight_reg <= inflight_next;
            err_reg      <= err_next;
        end
    end

    // DRAIN leaves as soon as the counter will reach zero, so done lands one cycle
    // after the final butterfly output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            blk_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        blk_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (issue)
                        blk_cnt_reg <= blk_cnt_reg + CW'(1);
                    if (abort || (issue && blk_cnt_reg == LAST_BLK))
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (inflight_next == '0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Tag delay line matching the butterfly latency; free-running, no enable.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
        logic [1:0] stage_in;
        logic [1:0] stage_reg;
        if (gi == 0) begin : g_first
            assign stage_in = {sof_in, eof_in};
        end else begin : g_next
            assign stage_in = g_tag[gi-1].stage_reg;
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                stage_reg <= '0;
            else
                stage_reg <= stage_in;
        end
    end

    assign tag_last = g_tag[LAT-1].stage_reg;
    assign out_sof  = tag_last[1] && bf_valid_out;
    assign out_eof  = tag_last[0] && bf_valid_out;
    assign blk_cnt  = blk_cnt_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_bfly22_sched.sv
// Randomized bench for bfly22_sched: a butterfly/downstream model plus a frame-level
// reference built from issue counts, a credit tally and a queue of expected tags.
module tb_bfly22_sched;

    localparam int BLK     = 32;
    localparam int LAT     = 2;
    localparam int CREDITS = 4;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic       bf_valid_out = 1'b0, credit_ret = 1'b0;
    logic       s_ready, bf_valid_in, out_sof, out_eof, busy, done, err;
    logic [5:0] blk_cnt;

    bfly22_sched #(.NUM(16), .BLK_PER_FRAME(BLK), .LAT(LAT), .CREDITS(CREDITS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .bf_valid_in(bf_valid_in),
        .bf_valid_out(bf_valid_out), .credit_ret(credit_ret),
        .out_sof(out_sof), .out_eof(out_eof), .blk_cnt(blk_cnt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { bit sof; bit eof; } tag_t;

    int   checks = 0, failures = 0;
    int   ph = P_IDLE, issued_m = 0, credit_m = CREDITS;
    bit   err_m = 1'b0;
    tag_t tq[$];
    logic [1:0] bf_pipe = '0, ret_pipe = '0;
    bit   ret_en = 1'b1, inj_vout = 1'b0, inj_ret = 1'b0;
    int   cyc = 0, last_vout_cyc = 0, done_cyc = 0, dut_issues = 0, frame_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: entered at a falling edge with the caller's inputs applied.
    task automatic cycle();
        bit   exp_sready, exp_issue, exp_sof, exp_eof, real_vout;
        tag_t t;
        real_vout    = bf_pipe[LAT-1];
        bf_valid_out = real_vout | inj_vout;
        credit_ret   = (ret_en & ret_pipe[1]) | inj_ret;
        #1;
        exp_sready = (ph == P_RUN) && (credit_m > 0) && !abort;
        exp_issue  = s_valid && exp_sready;
        check("s_ready", s_ready, exp_sready);
        check("bf_valid_in", bf_valid_in, exp_issue);
        check("busy", busy, (ph == P_RUN) || (ph == P_DRAIN));
        check("done", done, ph == P_DONE);
        check("blk_cnt", blk_cnt, issued_m);
        check("err", err, err_m);
        exp_sof = 1'b0;
        exp_eof = 1'b0;
        if (bf_valid_out) begin
            if (tq.size() == 0) err_m = 1'b1;
            else begin
                t = tq.pop_front();
                exp_sof = t.sof;
                exp_eof = t.eof;
            end
            last_vout_cyc = cyc;
        end
        check("out_sof", out_sof, exp_sof);
        check("out_eof", out_eof, exp_eof);
        if (done) done_cyc = cyc;
        if (bf_valid_in) dut_issues++;
        if (credit_ret && !exp_issue && credit_m == CREDITS) err_m = 1'b1;
        else credit_m = credit_m + int'(credit_ret) - int'(exp_issue);
        case (ph)
            P_IDLE: if (start) begin issued_m = 0; ph = P_RUN; end
            P_RUN: begin
                if (exp_issue) begin
                    tq.push_back('{sof: issued_m == 0, eof: issued_m == BLK - 1});
                    issued_m++;
                end
                if (abort || (exp_issue && issued_m == BLK)) ph = P_DRAIN;
            end
            P_DRAIN: if (tq.size() == 0) ph = P_DONE;
            default: ph = P_IDLE;
        endcase
        ret_pipe = {ret_pipe[0], real_vout};
        bf_pipe  = {bf_pipe[0], bf_valid_in};
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        #2;
        rstn = 1'b0;
        start = 1'b0; abort = 1'b0; inj_vout = 1'b0; inj_ret = 1'b0;
        bf_pipe = '0; ret_pipe = '0;
        bf_valid_out = 1'b0; credit_ret = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_bf_valid_in", bf_valid_in, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        ph = P_IDLE; issued_m = 0; credit_m = CREDITS; err_m = 1'b0;
        tq.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_frame(input int sv_pct, input int abort_after, input bit start_abort,
                             input bit check_gap);
        int n;
        int first_cyc;
        first_cyc = cyc;
        dut_issues = 0;
        start = 1'b1; abort = start_abort; s_valid = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        n = 0;
        while (ph != P_IDLE && n < 2000) begin
            s_valid = ($urandom_range(0, 99) < sv_pct);
            abort   = (abort_after >= 0) && (ph == P_RUN) && (issued_m == abort_after);
            cycle();
            n++;
        end
        abort = 1'b0; s_valid = 1'b0;
        check("frame_timeout", n < 2000, 1);
        check("frame_issues", dut_issues, (abort_after >= 0) ? abort_after : BLK);
        if (check_gap) check("done_gap", done_cyc - last_vout_cyc, 1);
        $display("frame %0d: issues=%0d blk_cnt=%0d cycles=%0d", frame_no, dut_issues,
                 blk_cnt, cyc - first_cyc);
        frame_no++;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("init_s_ready", s_ready, 0);
        check("init_blk_cnt", blk_cnt, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_err", err, 0);
        rstn = 1'b1;
        repeat (2) cycle();

        run_frame(100, -1, 1'b0, 1'b1);          // basic frame, s_valid held high
        repeat (6) cycle();
        run_frame(70, -1, 1'b1, 1'b1);           // start+abort together: start wins
        repeat (6) cycle();

        // Credit starvation with returns withheld
        ret_en = 1'b0; dut_issues = 0;
        start = 1'b1; cycle(); start = 1'b0;
        s_valid = 1'b1;
        repeat (12) cycle();
        check("starve_issues", dut_issues, CREDITS);
        s_valid = 1'b0;
        repeat (2) cycle();
        inj_ret = 1'b1; cycle(); inj_ret = 1'b0;
        s_valid = 1'b1;
        repeat (6) cycle();
        check("starve_one_more", dut_issues, CREDITS + 1);
        s_valid = 1'b0; abort = 1'b1; cycle(); abort = 1'b0;
        for (int i = 0; i < 20 && ph != P_IDLE; i++) cycle();
        check("starve_idle", busy, 0);
        reset_dut();
        ret_en = 1'b1;
        repeat (2) cycle();

        run_frame(100, 10, 1'b0, 1'b1);          // abort after 10 issues
        repeat (6) cycle();

        inj_vout = 1'b1; cycle(); inj_vout = 1'b0;   // spurious butterfly output in IDLE
        repeat (3) cycle();
        reset_dut();
        repeat (3) cycle();
        inj_ret = 1'b1; cycle(); inj_ret = 1'b0;     // credit return at full credit
        repeat (3) cycle();
        reset_dut();
        repeat (2) cycle();

        // Reset in the middle of a frame, then a clean frame
        start = 1'b1; cycle(); start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && issued_m < 5; i++) cycle();
        reset_dut();
        s_valid = 1'b0;
        repeat (2) cycle();
        run_frame(100, -1, 1'b0, 1'b1);
        repeat (6) cycle();

        for (int f = 0; f < 4; f++) begin
            run_frame($urandom_range(30, 95), -1, 1'b0, 1'b1);
            repeat ($urandom_range(4, 8)) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
